// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the word-serial wide adder.
//   DEF_DATA_WIDTH / DEF_MAX_WORDS : default word width and maximum words per operation
//   idx_width()                    : width of the word index for a given MAX_WORDS
//   state_t                        : sequencer state (FIRST word of an op, or RUN inside an op)
//   beat_t                         : one registered output beat
// Optional feature macro: WIDE_ADD_SEQ_OVF_EN adds the signed-overflow bit to beat_t.
package wide_add_seq_pkg;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_MAX_WORDS  = 16;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_MAX_WORDS);

  typedef enum logic {
    FIRST = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Field widths track the package defaults; a top built with other
  // DATA_WIDTH/MAX_WORDS values needs these defaults changed to match.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] s;
    logic [DEF_IDX_W-1:0]      idx;
    logic                      last;
    logic                      co;
    logic                      err;
`ifdef WIDE_ADD_SEQ_OVF_EN
    logic                      ovf;
`endif
  } beat_t;

endpackage

// File: rtl/word_adder.sv
// Purely combinational W-bit ripple-carry adder.
//   a, b   : operand words
//   ci     : carry into bit 0
//   s      : sum word (modulo 2^W)
//   co     : carry out of the MSB
//   c_msb  : carry into the MSB (only with WIDE_ADD_SEQ_OVF_EN, used for signed overflow)
module word_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
`ifdef WIDE_ADD_SEQ_OVF_EN
  output logic         c_msb,
`endif
  output logic         co
);

  // Carry is rippled through a procedural variable rather than a vector of
  // nets so the chain does not form a self-referencing net.
  always_comb begin : p_ripple
    logic c;
    s  = '0;
    c  = ci;
`ifdef WIDE_ADD_SEQ_OVF_EN
    c_msb = 1'b0;
`endif
    for (int i = 0; i < W; i++) begin
`ifdef WIDE_ADD_SEQ_OVF_EN
      if (i == W - 1) c_msb = c;
`endif
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Word-serial multi-word adder: chains the carry of a single word_adder
// across a stream of operand words (LSW first) and emits a registered
// stream of sum words with a valid/ready handshake on both sides.
//   clk, rst_n                  : clock, async active-low reset
//   in_a, in_b, in_ci           : operand words; in_ci used on the first word only
//   in_last, in_vld, in_rd      : input framing and handshake
//   out_s, out_idx              : sum word and its index within the operation
//   out_last, out_co, out_err   : last beat, final carry-out, truncated at MAX_WORDS
//   out_ovf                     : signed overflow on last beat (WIDE_ADD_SEQ_OVF_EN only)
//   out_vld, out_rd             : output handshake
// Optional feature macro: WIDE_ADD_SEQ_OVF_EN. MAX_WORDS must be at least 2.
module wide_add_sequencer
  import wide_add_seq_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  MAX_WORDS  = DEF_MAX_WORDS,
  localparam int IDX_W      = idx_width(MAX_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_ci,
  input  logic                  in_last,
  input  logic                  in_vld,
  output logic                  in_rd,
  output logic [DATA_WIDTH-1:0] out_s,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  out_co,
  output logic                  out_err,
`ifdef WIDE_ADD_SEQ_OVF_EN
  output logic                  out_ovf,
`endif
  output logic                  out_vld,
  input  logic                  out_rd
);

  state_t          state_q, state_d;
  logic            carry_q, carry_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  beat_t           beat_q, beat_d;
  logic            vld_q, vld_d;

  logic                  in_xfer;
  logic                  cin_sel;
  logic [DATA_WIDTH-1:0] s_w;
  logic                  co_w;
  logic                  forced;
  logic                  word_last;
`ifdef WIDE_ADD_SEQ_OVF_EN
  logic                  c_msb_w;
`endif

  // Single output register: accept whenever it is empty or draining.
  assign in_rd   = !vld_q | out_rd;
  assign in_xfer = in_vld & in_rd;
  assign cin_sel = (state_q == FIRST) ? in_ci : carry_q;

  word_adder #(.W(DATA_WIDTH)) u_word_adder (
    .a     (in_a),
    .b     (in_b),
    .ci    (cin_sel),
    .s     (s_w),
`ifdef WIDE_ADD_SEQ_OVF_EN
    .c_msb (c_msb_w),
`endif
    .co    (co_w)
  );

  // The MAX_WORDS-th word closes the operation even without in_last.
  assign forced    = (state_q == RUN) && (cnt_q == IDX_W'(MAX_WORDS - 1)) && !in_last;
  assign word_last = in_last | forced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FIRST;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      beat_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    vld_d   = vld_q;
    if (in_xfer) begin
      vld_d       = 1'b1;
      beat_d.s    = s_w;
      beat_d.idx  = cnt_q;
      beat_d.last = word_last;
      beat_d.co   = word_last & co_w;
      beat_d.err  = forced;
`ifdef WIDE_ADD_SEQ_OVF_EN
      beat_d.ovf  = word_last & (c_msb_w ^ co_w);
`endif
      if (word_last) begin
        state_d = FIRST;
        cnt_d   = '0;
        carry_d = 1'b0;
      end else begin
        state_d = RUN;
        cnt_d   = cnt_q + IDX_W'(1);
        carry_d = co_w;
      end
    end else if (out_rd) begin
      vld_d = 1'b0;
    end
  end

  assign out_vld  = vld_q;
  assign out_s    = beat_q.s;
  assign out_idx  = beat_q.idx;
  assign out_last = beat_q.last;
  assign out_co   = beat_q.co;
  assign out_err  = beat_q.err;
`ifdef WIDE_ADD_SEQ_OVF_EN
  assign out_ovf  = beat_q.ovf;
`endif

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: directed scenarios plus
// randomized multi-word operations scored against whole-number arithmetic.
module tb_wide_add_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_a, in_b;
  logic       in_ci, in_last, in_vld, in_rd;
  logic [3:0] out_s, out_idx;
  logic       out_last, out_co, out_err, out_vld, out_rd;
  logic       ovf_act;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic       last;
  } word_t;

  word_t       wq[$];
  logic [11:0] bq[$];

  always #5 clk = ~clk;

`ifdef WIDE_ADD_SEQ_OVF_EN
  logic out_ovf;
  assign ovf_act = out_ovf;
`else
  assign ovf_act = 1'b0;
`endif

  wide_add_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_ci    (in_ci),
    .in_last  (in_last),
    .in_vld   (in_vld),
    .in_rd    (in_rd),
    .out_s    (out_s),
    .out_idx  (out_idx),
    .out_last (out_last),
    .out_co   (out_co),
    .out_err  (out_err),
`ifdef WIDE_ADD_SEQ_OVF_EN
    .out_ovf  (out_ovf),
`endif
    .out_vld  (out_vld),
    .out_rd   (out_rd)
  );

  // Drive one word from a negedge; it transfers on the next posedge (out_rd
  // is held high by callers) and the call returns on the following negedge.
  task automatic put(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic last);
    in_a = a; in_b = b; in_ci = ci; in_last = last; in_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  // Append one operation of n words to the stimulus and expected-beat queues.
  task automatic add_op(input int n, input logic [63:0] a_in, input logic [63:0] b_in, input logic ci);
    logic [63:0] a, b, mask;
    logic [64:0] sum;
    logic        ovf, last;
    int          w;
    w    = 4 * n;
    mask = (n == 16) ? '1 : ((64'd1 << w) - 64'd1);
    a    = a_in & mask;
    b    = b_in & mask;
    sum  = {1'b0, a} + {1'b0, b} + {64'd0, ci};
    ovf  = (a[w-1] == b[w-1]) && (sum[w-1] != a[w-1]);
`ifndef WIDE_ADD_SEQ_OVF_EN
    ovf  = 1'b0;
`endif
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      wq.push_back('{a: a[4*i+:4], b: b[4*i+:4], ci: (i == 0) ? ci : 1'($urandom), last: last});
      bq.push_back({sum[4*i+:4], 4'(i), last, last & sum[w], 1'b0, last & ovf});
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_vld = 1'b0; in_a = '0; in_b = '0; in_ci = 1'b0; in_last = 1'b0; out_rd = 1'b1;
    #1;
    n_chk++;
    if ({out_vld, out_s, out_idx, out_last, out_co, out_err, ovf_act} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 000", {out_vld, out_s, out_idx, out_last, out_co, out_err, ovf_act});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (in_rd !== 1'b1) begin n_fail++; $display("FAIL reset_in_rd: got %b expected 1", in_rd); end
  endtask

  task automatic test_single_word;
    put(4'h9, 4'h8, 1'b1, 1'b1);
    n_chk++;
    if ({out_vld, out_s, out_idx, out_last, out_co, out_err} !== {1'b1, 4'h2, 4'h0, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_word: got vld=%b s=%h idx=%0d last=%b co=%b err=%b expected 1 2 0 1 1 0",
               out_vld, out_s, out_idx, out_last, out_co, out_err);
    end
  endtask

  task automatic test_three_word;
    logic [3:0] a[3] = '{4'hF, 4'hF, 4'h0};
    logic [3:0] b[3] = '{4'h1, 4'h0, 4'h0};
    logic [3:0] s[3] = '{4'h0, 4'h0, 4'h1};
    for (int i = 0; i < 3; i++) begin
      put(a[i], b[i], 1'b0, i == 2);
      n_chk++;
      if ({out_vld, out_s, out_idx, out_last, out_co, out_err} !== {1'b1, s[i], 4'(i), i == 2, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL three_word[%0d]: got s=%h idx=%0d last=%b co=%b err=%b expected s=%h idx=%0d last=%b co=0",
                 i, out_s, out_idx, out_last, out_co, out_err, s[i], i, i == 2);
      end
    end
  endtask

  task automatic test_carry_chain;
    for (int i = 0; i < 3; i++) begin
      put(4'hF, 4'h0, 1'b1, i == 2);
      n_chk++;
      if ({out_s, out_idx, out_last, out_co} !== {4'h0, 4'(i), i == 2, i == 2}) begin
        n_fail++;
        $display("FAIL carry_chain[%0d]: got s=%h idx=%0d last=%b co=%b expected s=0 idx=%0d last=%b co=%b",
                 i, out_s, out_idx, out_last, out_co, i, i == 2, i == 2);
      end
    end
  endtask

  // 0x9C5 + 0x4B8 + 1 = 0xE7E, no final carry; stalled after the first beat.
  task automatic test_backpressure;
    put(4'h5, 4'h8, 1'b1, 1'b0);
    n_chk++;
    if ({out_s, out_idx} !== {4'hE, 4'h0}) begin
      n_fail++; $display("FAIL bp_beat0: got s=%h idx=%0d expected s=e idx=0", out_s, out_idx);
    end
    out_rd = 1'b0;
    in_a = 4'hC; in_b = 4'hB; in_ci = 1'b0; in_last = 1'b0; in_vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_chk++;
      if ({in_rd, out_vld, out_s, out_idx} !== {1'b0, 1'b1, 4'hE, 4'h0}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got in_rd=%b vld=%b s=%h idx=%0d expected 0 1 e 0", k, in_rd, out_vld, out_s, out_idx);
      end
      @(negedge clk);
    end
    out_rd = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    n_chk++;
    if ({out_vld, out_s, out_idx, out_last} !== {1'b1, 4'h7, 4'h1, 1'b0}) begin
      n_fail++; $display("FAIL bp_beat1: got vld=%b s=%h idx=%0d last=%b expected 1 7 1 0", out_vld, out_s, out_idx, out_last);
    end
    put(4'h9, 4'h4, 1'b0, 1'b1);
    n_chk++;
    if ({out_s, out_idx, out_last, out_co} !== {4'hE, 4'h2, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL bp_beat2: got s=%h idx=%0d last=%b co=%b expected e 2 1 0", out_s, out_idx, out_last, out_co);
    end
  endtask

  task automatic test_truncation;
    for (int i = 0; i < 16; i++) begin
      put(4'hF, 4'h0, i == 0, 1'b0);
      n_chk++;
      if ({out_s, out_idx, out_last, out_co, out_err} !== {4'h0, 4'(i), i == 15, i == 15, i == 15}) begin
        n_fail++;
        $display("FAIL trunc[%0d]: got s=%h idx=%0d last=%b co=%b err=%b expected s=0 idx=%0d last/co/err=%b",
                 i, out_s, out_idx, out_last, out_co, out_err, i, i == 15);
      end
    end
    put(4'h1, 4'h1, 1'b1, 1'b1);
    n_chk++;
    if ({out_s, out_idx, out_last, out_co, out_err} !== {4'h3, 4'h0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL trunc_next_first: got s=%h idx=%0d last=%b co=%b err=%b expected 3 0 1 0 0",
               out_s, out_idx, out_last, out_co, out_err);
    end
  endtask

  task automatic test_async_reset;
    put(4'hF, 4'h1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_vld, out_s, out_idx} !== 9'h000) begin
      n_fail++; $display("FAIL async_reset: got vld=%b s=%h idx=%0d expected 0 0 0", out_vld, out_s, out_idx);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    put(4'h1, 4'h1, 1'b0, 1'b1);
    n_chk++;
    if ({out_vld, out_s, out_idx, out_last, out_co} !== {1'b1, 4'h2, 4'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL after_reset_op: got vld=%b s=%h idx=%0d last=%b co=%b expected 1 2 0 1 0",
               out_vld, out_s, out_idx, out_last, out_co);
    end
  endtask

  task automatic test_back_to_back;
    put(4'hF, 4'hF, 1'b1, 1'b1);
    n_chk++;
    if ({out_s, out_idx, out_last, out_co} !== {4'hF, 4'h0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL b2b_op0: got s=%h idx=%0d last=%b co=%b expected f 0 1 1", out_s, out_idx, out_last, out_co);
    end
    put(4'h1, 4'h2, 1'b0, 1'b1);
    n_chk++;
    if ({out_s, out_idx, out_last, out_co} !== {4'h3, 4'h0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL b2b_op1: got s=%h idx=%0d last=%b co=%b expected 3 0 1 0", out_s, out_idx, out_last, out_co);
    end
  endtask

`ifdef WIDE_ADD_SEQ_OVF_EN
  task automatic test_ovf;
    put(4'h7, 4'h1, 1'b0, 1'b1);
    n_chk++;
    if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_7p1: got %b expected 1", out_ovf); end
    put(4'h7, 4'h7, 1'b0, 1'b0);
    n_chk++;
    if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_nonlast: got %b expected 0", out_ovf); end
    put(4'h0, 4'h0, 1'b0, 1'b1);
    n_chk++;
    if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_0x0E: got %b expected 0", out_ovf); end
  endtask
`endif

  // Random operations with random input gaps and output stalls (stall_pct %).
  task automatic test_random_stream(input int n_ops, input int stall_pct);
    int wi, cyc;
    logic [11:0] act;
    wq.delete(); bq.delete();
    out_rd = 1'b1; in_vld = 1'b0;
    @(negedge clk);
    for (int k = 0; k < n_ops; k++)
      add_op($urandom_range(1, 16), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    wi = 0; cyc = 0;
    while ((wi < wq.size() || bq.size() > 0) && cyc < 20000) begin
      out_rd = ($urandom_range(0, 99) >= stall_pct);
      if (wi < wq.size() && $urandom_range(0, 3) != 0) begin
        in_a = wq[wi].a; in_b = wq[wi].b; in_ci = wq[wi].ci; in_last = wq[wi].last; in_vld = 1'b1;
      end else begin
        in_vld = 1'b0; in_a = 4'($urandom); in_b = 4'($urandom);
      end
      #1;
      n_chk++;
      if (in_rd !== (!out_vld | out_rd)) begin
        n_fail++; $display("FAIL rnd_in_rd: got %b expected %b", in_rd, !out_vld | out_rd);
      end
      act = {out_s, out_idx, out_last, out_co, out_err, ovf_act};
      if (out_vld === 1'b1 && out_rd) begin
        n_chk++;
        if (bq.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra_beat: got beat %h expected none", act);
        end else begin
          if (act !== bq[0]) begin
            n_fail++; $display("FAIL rnd_beat: got s/idx/last/co/err/ovf=%h expected %h", act, bq[0]);
          end
          void'(bq.pop_front());
        end
      end
      if (in_vld && in_rd) wi++;
      @(negedge clk);
      cyc++;
    end
    in_vld = 1'b0; out_rd = 1'b1;
    n_chk++;
    if (cyc >= 20000) begin
      n_fail++; $display("FAIL rnd_timeout: got %0d words/%0d beats left expected 0", wq.size() - wi, bq.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_three_word();
    test_carry_chain();
    test_backpressure();
    test_truncation();
    test_async_reset();
    test_back_to_back();
`ifdef WIDE_ADD_SEQ_OVF_EN
    test_ovf();
`endif
    test_random_stream(30, 0);
    test_random_stream(30, 40);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Word-serial multi-word adder that sits directly upstream of the word-level ripple adder. It instantiates that adder's function as a combinational sub-module and wraps it in a carry-chaining sequencer.
- Accepts a stream of operand word pairs (least-significant word first), adds each pair plus the chained carry, and emits a registered stream of sum words.
- The carry-out of the final word accompanies the last output beat.
- Lets one DATA_WIDTH adder implement additions of up to MAX_WORDS*DATA_WIDTH bits.

Parameters:
DATA_WIDTH  4   bits per operand/sum word
MAX_WORDS   16  maximum words per operation; IDX_W = clog2(MAX_WORDS)

Ports:
clk        in   1           single clock; all state rising-edge
rst_n      in   1           asynchronous, active-low reset
in_a       in   DATA_WIDTH  operand A word
in_b       in   DATA_WIDTH  operand B word
in_ci      in   1           carry-in, sampled only on the first word of an operation
in_last    in   1           marks the most-significant word
in_vld     in   1           input valid
in_rd      out  1           input ready
out_s      out  DATA_WIDTH  sum word
out_idx    out  IDX_W       word index within the operation (0 = LSW)
out_last   out  1           last sum word of the operation
out_co     out  1           final carry-out; meaningful only when out_last=1, else 0
out_err    out  1           operation truncated at MAX_WORDS (with out_last)
out_vld    out  1           output valid
out_rd     in   1           output ready

Behaviour:
- Reset (async, rst_n=0):
  - out_vld=0, out_s=0, out_idx=0, out_last=0, out_co=0, out_err=0.
  - carry register=0, word counter=0, state=FIRST.
  - Reset mid-operation discards the partial operation and any held output beat.
- Handshakes:
  - Input transfer: in_vld & in_rd. Output transfer: out_vld & out_rd.
  - in_rd = !out_vld | out_rd (single output register, no combinational path from in_vld to in_rd).
  - out_* fields stay stable while out_vld=1 and out_rd=0.
- Datapath:
  - Combinational sum: {co_w, s_w} = in_a + in_b + cin_sel.
  - cin_sel = in_ci in state FIRST; cin_sel = carry register in state RUN.
  - Arithmetic is unsigned, modulo 2^DATA_WIDTH per word; co_w is the word carry.
- On each input transfer:
  - Output register loads out_s=s_w and out_idx=counter; out_vld=1 on the next edge (latency 1 cycle).
  - The carry register loads co_w.
- Output register when no input transfer: if out_rd=1, out_vld clears to 0; otherwise the register holds.
- State machine (transitions on input transfer only):
  - FIRST -> RUN when in_last=0 (counter <- 1).
  - FIRST -> FIRST when in_last=1: single-word operation, out_last=1, out_co=co_w.
  - RUN -> RUN when in_last=0 and counter < MAX_WORDS-1 (counter+1).
  - RUN -> FIRST when in_last=1: out_last=1, out_co=co_w, counter <- 0, carry <- 0.
  - RUN -> FIRST when counter == MAX_WORDS-1 and in_last=0: forced last. out_last=1, out_err=1, out_co=co_w, counter <- 0, carry <- 0.
- out_err=0 on every beat except a forced last.
- Back-to-back operations are supported at full throughput: the first word of the next operation may transfer in the cycle after the previous last word, or in the same cycle the previous last beat is consumed.
- Throughput: 1 word/cycle while out_rd=1. With out_rd=0 and out_vld=1, in_rd=0 and no state changes.

Optional Feature:
- Macro: WIDE_ADD_SEQ_OVF_EN.
- Defined:
  - Extra output port out_ovf (1 bit), registered with the other out_* fields.
  - On the last beat, out_ovf = signed two's-complement overflow of the full-width addition = (carry into the MSB of the last word) XOR co_w.
  - out_ovf=0 on non-last beats; reset value 0.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package wide_add_seq_pkg:
  - DATA_WIDTH and MAX_WORDS defaults, IDX_W derivation.
  - State enum {FIRST, RUN}.
  - Output beat struct (s, idx, last, co, err[, ovf]).
- One sub-module, word_adder: purely combinational DATA_WIDTH ripple adder (a, b, ci -> s, co, plus carry into the MSB for the overflow option).
- The sequencer owns all registers.

Test Plan:
- Single-word op: in_a=4'h9, in_b=4'h8, in_ci=1, in_last=1, out_rd=1 -> next cycle out_s=4'h2, out_co=1, out_last=1, out_idx=0, out_err=0.
- 3-word op, ci=0: A=0x0FF, B=0x001, LSW first -> beats out_s=0,0,1; idx 0,1,2; out_co=0 on last beat only.
- Carry chain, ci=1: A=0xFFF, B=0x000 -> out_s=0,0,0 and out_co=1 with out_last on idx 2.
- Backpressure: out_rd=0 for 5 cycles mid-op -> in_rd=0; out_s/out_idx held stable; carry unchanged; resuming yields a correct sum.
- Truncation: 16 words with in_last=0 -> beat idx 15 has out_last=1, out_err=1; next word is treated as FIRST using in_ci.
- Async reset mid-op: after word 1 of 3, pulse rst_n=0 -> out_vld=0 immediately; new op 0x1+0x1 -> out_s=2, idx=0. With WIDE_ADD_SEQ_OVF_EN, 4'h7+4'h1 single word -> out_ovf=1.
